// File: rtl/wb_burst_ram_slave_if.sv
// wb_burst_ram_slave_if: Wishbone B4 bus bundle between an interconnect slave port and a burst-capable slave
interface wb_burst_ram_slave_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [3:0]    wbs_sel_i;
  logic          wbs_we_i;
  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic [2:0]    wbs_cti_i;
  logic [1:0]    wbs_bte_i;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_ack_o;
  logic          wbs_err_o;
  logic          wbs_rty_o;
  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// wb_burst_ram_slave: Wishbone B4 registered-feedback RAM slave with classic cycles and CTI/BTE bursts
module wb_burst_ram_slave #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W = $clog2(MEM_WORDS)
) (
  input logic i_clk,
  input logic i_rst,
  wb_burst_ram_slave_if.slave wb
);
  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;
  state_t state, state_n;
  logic ack_q, ack_n, err_q, err_n, req, cont, wr, ok;
  logic [AW-3:0] cnt, cnt_n, mask, adv, look;
  logic [DW-1:0] dat_q, dat_n, cur, wdat, rd;
  logic [DW-1:0] mem [MEM_WORDS];
  logic unused_adr;
  assign unused_adr = ^wb.wbs_adr_i[1:0];
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign cont = wb.wbs_cti_i == 3'b001 || wb.wbs_cti_i == 3'b010;
  assign wr = state != IDLE && ack_q && req && wb.wbs_we_i;
  assign wb.wbs_ack_o = ack_q & req;
  assign wb.wbs_err_o = err_q & req;
  assign wb.wbs_rty_o = 1'b0;
  assign wb.wbs_dat_o = dat_q;
  // wrap bursts only step the low bits; linear uses an all-ones mask so the counter runs past the RAM end
  assign mask = wb.wbs_bte_i == 2'b01 ? (AW-2)'(3) :
                wb.wbs_bte_i == 2'b10 ? (AW-2)'(7) :
                wb.wbs_bte_i == 2'b11 ? (AW-2)'(15) : '1;
  assign adv = wb.wbs_cti_i == 3'b010 ? (cnt & ~mask) | ((cnt + (AW-2)'(1)) & mask) : cnt;
  assign look = state == IDLE ? wb.wbs_adr_i[AW-1:2] : adv;
  assign ok = look[AW-3:IDX_W] == '0;
  always_comb begin
    cur = mem[cnt[IDX_W-1:0]];
    wdat = cur;
    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wb.wbs_sel_i[i] ? wb.wbs_dat_i[8*i +: 8] : cur[8*i +: 8];
  end
  // a constant-address write must be visible on the very next beat's prefetched data
  assign rd = wr && look == cnt ? wdat : mem[look[IDX_W-1:0]];
  always_comb begin
    state_n = state;
    ack_n = ack_q;
    err_n = err_q;
    cnt_n = cnt;
    dat_n = dat_q;
    if (state == IDLE) begin
      if (req) begin
        state_n = cont ? BURST : CLASSIC;
        cnt_n = look;
        ack_n = ok;
        err_n = !ok;
        dat_n = ok ? rd : '0;
      end
    end else if (!wb.wbs_cyc_i || state == CLASSIC || (wb.wbs_stb_i && !cont)) begin
      state_n = IDLE;
      ack_n = 1'b0;
      err_n = 1'b0;
    end else if (wb.wbs_stb_i) begin
      cnt_n = adv;
      ack_n = ok;
      err_n = !ok;
      dat_n = ok ? rd : '0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      dat_q <= '0;
    end else begin
      state <= state_n;
      ack_q <= ack_n;
      err_q <= err_n;
      cnt <= cnt_n;
      dat_q <= dat_n;
    end
  end
  always_ff @(posedge i_clk) if (wr) mem[cnt[IDX_W-1:0]] <= wdat;
endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// tb_wb_burst_ram_slave: directed checks of classic, byte-lane, burst, range, stall and reset behaviour
module tb_wb_burst_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  logic b_ack [16];
  logic b_err [16];
  logic [31:0] b_dat [16];
  logic [31:0] e4 [4];
  wb_burst_ram_slave_if bus ();
  wb_burst_ram_slave dut (.i_clk(clk), .i_rst(rst), .wb(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic release_bus();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
  endtask
  task automatic classic(input logic w, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, input logic e, input logic [31:0] exp);
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = sel;
    bus.wbs_we_i = w;
    bus.wbs_cti_i = 3'b000;
    bus.wbs_bte_i = 2'b00;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    #1 check("cl_pre_ack", 32'(bus.wbs_ack_o | bus.wbs_err_o), 0);
    @(posedge clk); #1;
    check("cl_ack", 32'(bus.wbs_ack_o), 32'(!e));
    check("cl_err", 32'(bus.wbs_err_o), 32'(e));
    if (!w) check("cl_rdata", bus.wbs_dat_o, exp);
    @(posedge clk); #1;
    check("cl_post_ack", 32'(bus.wbs_ack_o | bus.wbs_err_o), 0);
    release_bus();
  endtask
  task automatic burst(input logic w, input logic [2:0] ct, input logic [1:0] bt, input logic [31:0] adr,
                       input int n, input int st, input int sl, input logic [31:0] base);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i = w;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_bte_i = bt;
    bus.wbs_cti_i = n == 1 ? 3'b111 : ct;
    bus.wbs_dat_i = base;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      if (k == st) begin
        bus.wbs_stb_i = 1'b0;
        for (int j = 0; j < sl; j++) begin
          #1 check("stall_ack", 32'(bus.wbs_ack_o | bus.wbs_err_o), 0);
          @(posedge clk); #1;
        end
        bus.wbs_stb_i = 1'b1;
      end
      #1;
      b_ack[k] = bus.wbs_ack_o;
      b_err[k] = bus.wbs_err_o;
      b_dat[k] = bus.wbs_dat_o;
      @(posedge clk); #1;
      bus.wbs_cti_i = k + 2 == n ? 3'b111 : ct;
      bus.wbs_dat_i = base + 32'(k + 1);
    end
    check("burst_end", 32'(bus.wbs_ack_o | bus.wbs_err_o), 0);
    release_bus();
  endtask
  initial begin
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_we_i = 1'b0;
    bus.wbs_cti_i = 3'b000;
    bus.wbs_bte_i = 2'b00;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.wbs_ack_o), 0);
    check("rst_err", 32'(bus.wbs_err_o), 0);
    check("rst_dat", bus.wbs_dat_o, 0);
    check("rst_rty", 32'(bus.wbs_rty_o), 0);
    release_bus();
    rst = 1'b0;
    @(posedge clk); #1;
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    classic(1'b0, 32'h10, 0, 4'hF, 1'b0, 32'hDEADBEEF);
    classic(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 0);
    classic(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 0);
    classic(1'b0, 32'h20, 0, 4'hF, 1'b0, 32'hAA22AA44);
    classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 0);
    classic(1'b0, 32'h20, 0, 4'hF, 1'b0, 32'hAA22AA44);
    classic(1'b0, 32'h1000, 0, 4'hF, 1'b1, 0);
    classic(1'b1, 32'hFFFFFFF0, 32'h1234, 4'hF, 1'b1, 0);
    burst(1'b1, 3'b010, 2'b00, 32'h0, 16, -1, 0, 32'h1000);
    for (int k = 0; k < 16; k++) check($sformatf("fill_ack%0d", k), 32'(b_ack[k]), 1);
    burst(1'b0, 3'b010, 2'b01, 32'h0C, 4, -1, 0, 0);
    e4 = '{32'h1003, 32'h1000, 32'h1001, 32'h1002};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap4_ack%0d", k), 32'(b_ack[k]), 1);
      check($sformatf("wrap4_dat%0d", k), b_dat[k], e4[k]);
    end
    burst(1'b0, 3'b010, 2'b10, 32'h34, 4, -1, 0, 0);
    e4 = '{32'h100D, 32'h100E, 32'h100F, 32'h1008};
    for (int k = 0; k < 4; k++) check($sformatf("wrap8_dat%0d", k), b_dat[k], e4[k]);
    burst(1'b1, 3'b010, 2'b00, 32'hFF8, 4, -1, 0, 32'hC0DE0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("edge_ack%0d", k), 32'(b_ack[k]), 32'(k < 2));
      check($sformatf("edge_err%0d", k), 32'(b_err[k]), 32'(k >= 2));
    end
    check("edge_errdat2", b_dat[2], 0);
    check("edge_errdat3", b_dat[3], 0);
    classic(1'b0, 32'h0, 0, 4'hF, 1'b0, 32'h1000);
    classic(1'b0, 32'h4, 0, 4'hF, 1'b0, 32'h1001);
    classic(1'b0, 32'hFF8, 0, 4'hF, 1'b0, 32'hC0DE0000);
    classic(1'b0, 32'hFFC, 0, 4'hF, 1'b0, 32'hC0DE0001);
    burst(1'b0, 3'b010, 2'b00, 32'h0, 8, 2, 2, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stall_beat_ack%0d", k), 32'(b_ack[k]), 1);
      check($sformatf("stall_dat%0d", k), b_dat[k], 32'h1000 + 32'(k));
    end
    burst(1'b1, 3'b001, 2'b00, 32'h40, 3, -1, 0, 32'h5000);
    classic(1'b0, 32'h40, 0, 4'hF, 1'b0, 32'h5002);
    burst(1'b0, 3'b001, 2'b00, 32'h14, 3, -1, 0, 0);
    for (int k = 0; k < 3; k++) check($sformatf("const_dat%0d", k), b_dat[k], 32'h1005);
    bus.wbs_adr_i = 32'h0;
    bus.wbs_we_i = 1'b0;
    bus.wbs_bte_i = 2'b00;
    bus.wbs_cti_i = 3'b010;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    check("rb_ack0", 32'(bus.wbs_ack_o), 1);
    check("rb_dat0", bus.wbs_dat_o, 32'h1000);
    @(posedge clk); #1;
    check("rb_dat1", bus.wbs_dat_o, 32'h1001);
    #2 rst = 1'b1;
    #1;
    check("rb_ack_drop", 32'(bus.wbs_ack_o), 0);
    check("rb_err_drop", 32'(bus.wbs_err_o), 0);
    check("rb_dat_clr", bus.wbs_dat_o, 0);
    rst = 1'b0;
    release_bus();
    @(posedge clk); #1;
    classic(1'b0, 32'h10, 0, 4'hF, 1'b0, 32'h1004);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
